db_left_ram_ctrl: RTL
=====================

Name: db_left_ram_ctrl

Overview:
- Single-port access controller for the deblocking left-pixel RAM (16 x 128-bit entries holding Y/Cb/Cr left columns, active-low cen/ren/wen, 1-cycle synchronous read).
- Arbitrates the filter fetch path (reads of left-neighbour pixels) against the filter write-back path (right column of the current LCU) with round-robin priority and a write-first rule on address collisions.
- Returns zero data when no left LCU exists, and tracks per-LCU write completion.

Parameters:
- DATA_WIDTH, 128, RAM word width
- ADDR_WIDTH, 4, RAM address width
- WR_NUM, 16, writes per LCU that complete it (1..2^ADDR_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- lcu_start_i  in  1  one-cycle pulse at start of each LCU
- lft_avail_i  in  1  left LCU exists; sampled on lcu_start_i
- rd_req_i  in  1  read request, held until granted
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_gnt_o  out  1  read granted this cycle
- rd_vld_o  out  1  read data valid
- rd_data_o  out  DATA_WIDTH  read data
- wr_req_i  in  1  write request, held until granted
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  DATA_WIDTH  write data
- wr_gnt_o  out  1  write granted this cycle
- lcu_done_o  out  1  one-cycle pulse when WR_NUM writes have been accepted
- ram_cen_o  out  1  RAM chip enable, low active
- ram_wen_o  out  1  RAM write enable, low active
- ram_ren_o  out  1  RAM output enable, low active
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_data_o  out  DATA_WIDTH  RAM write data
- ram_data_i  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset values: state IDLE, rd_gnt_o=0, wr_gnt_o=0, rd_vld_o=0, rd_data_o=0, lcu_done_o=0, ram_cen_o=1, ram_wen_o=1, ram_ren_o=1, ram_addr_o=0, ram_data_o=0.
- Reset internals: wr_cnt=0, avail_r=0, last_wr_r=0.
- FSM states:
  - IDLE: no grants.
  - RUN: reads and writes are arbitrated.
  - DONE: reads only; write requests are held off.
- FSM transitions:
  - lcu_start_i in any state -> RUN. Clears wr_cnt, latches avail_r=lft_avail_i. No grant in the lcu_start_i cycle.
  - RUN -> DONE on the cycle the WR_NUM-th write is granted. lcu_done_o pulses high the following cycle.
- Arbitration is combinational within the cycle.
  - Only one requester: it is granted.
  - Both requesting, rd_addr_i==wr_addr_i: write wins (read sees new data on its later grant).
  - Both requesting, addresses differ: the requester not granted last wins. last_wr_r updates on every grant and is not cleared by lcu_start_i.
- RAM drive, same cycle as the grant:
  - Write grant: cen=0, wen=0, addr=wr_addr_i, data=wr_data_i.
  - Read grant with avail_r=1: cen=0, wen=1, addr=rd_addr_i.
  - Read grant with avail_r=0: cen stays 1 (no RAM access).
  - No grant: cen=1, wen=1.
  - ram_ren_o=0 only in the cycle after a RAM read.
- Read latency is 1 cycle. rd_vld_o is registered high the cycle after rd_gnt_o.
  - avail_r=1: rd_data_o=ram_data_i.
  - avail_r=0: rd_data_o=0.
  - rd_data_o holds its last value when rd_vld_o=0.
- Back-to-back grants are allowed every cycle; throughput is one access per cycle.
- wr_cnt saturates at WR_NUM. Writes are never granted in DONE or IDLE.
- A read granted before an lcu_start_i still completes its rd_vld_o in the start cycle, using the avail_r value captured at grant.
- Mid-operation rst_n assertion immediately forces the reset values and drops in-flight read valid.

Test Plan:
- Reset, then lcu_start_i with lft_avail_i=1; write 16 addresses 0..15 with data = addr*0x11 replicated -> wr_gnt_o every cycle, lcu_done_o pulses one cycle after the 16th grant, state DONE.
- In DONE, wr_req_i=1 and rd_req_i=1 addr 5 -> only rd_gnt_o=1; rd_vld_o next cycle with data 0x55..55; ram_ren_o=0 that cycle.
- New LCU, both requesters continuous, different addresses -> grants alternate rd/wr each cycle. Same address 3 -> wr_gnt_o first, then the read returns the new data.
- lcu_start_i with lft_avail_i=0, read addr 7 -> ram_cen_o stays 1, rd_vld_o=1 next cycle with rd_data_o=0.
- Read granted in the cycle before lcu_start_i -> rd_vld_o in the start cycle with correct data; no grant in the start cycle despite pending requests.
- rst_n pulled low the cycle after a read grant -> rd_vld_o=0, gnts=0, ram_cen_o=1, state IDLE; no grants until the next lcu_start_i.

Source files
------------

// File: rtl/db_left_ram_ctrl.sv
// Access controller for the deblocking left-pixel RAM (16 x 128-bit).
// Ports: lcu_start_i/lft_avail_i (LCU control), rd_* (fetch path),
//   wr_* (write-back path), lcu_done_o, ram_* (single-port RAM).
module db_left_ram_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int WR_NUM     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lcu_start_i,
    input  logic                  lft_avail_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_vld_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_gnt_o,
    output logic                  lcu_done_o,
    output logic                  ram_cen_o,
    output logic                  ram_wen_o,
    output logic                  ram_ren_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int CW = $clog2(WR_NUM + 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_NUM - 1);
    localparam logic [CW-1:0] WR_FULL = CW'(WR_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt;
    logic                  avail_r;
    logic                  last_wr_r;
    logic                  rd_avail_r;
    logic                  rd_vld_r;
    logic                  ren_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  rd_ok, wr_ok;
    logic                  rd_gnt, wr_gnt;
    logic                  ram_rd;

    // Arbitration and next state
    always_comb begin
        state_d = state_q;
        rd_gnt  = 1'b0;
        wr_gnt  = 1'b0;
        rd_ok   = rd_req_i && !lcu_start_i &&
                  (state_q == RUN || state_q == DONE);
        wr_ok   = wr_req_i && !lcu_start_i && (state_q == RUN);
        if (rd_ok && wr_ok) begin
            // Same address: write first so the read sees fresh data
            if (rd_addr_i == wr_addr_i || !last_wr_r) begin
                wr_gnt = 1'b1;
            end else begin
                rd_gnt = 1'b1;
            end
        end else begin
            rd_gnt = rd_ok;
            wr_gnt = wr_ok;
        end
        unique case (1'b1)
            lcu_start_i:                  state_d = RUN;
            wr_gnt && wr_cnt == WR_LAST:  state_d = DONE;
            default: ;
        endcase
    end

    // Reads without a left LCU never touch the RAM
    assign ram_rd = rd_gnt && avail_r;

    always_comb begin
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = '0;
        ram_data_o = '0;
        unique case (1'b1)
            wr_gnt: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_addr_o = wr_addr_i;
                ram_data_o = wr_data_i;
            end
            ram_rd: begin
                ram_cen_o  = 1'b0;
                ram_addr_o = rd_addr_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            avail_r    <= 1'b0;
            last_wr_r  <= 1'b0;
            rd_avail_r <= 1'b0;
            rd_vld_r   <= 1'b0;
            ren_r      <= 1'b1;
            done_r     <= 1'b0;
            hold_r     <= '0;
        end else begin
            if (lcu_start_i) begin
                wr_cnt  <= '0;
                avail_r <= lft_avail_i;
            end else if (wr_gnt && wr_cnt != WR_FULL) begin
                wr_cnt <= wr_cnt + CW'(1);
            end
            if (rd_gnt || wr_gnt) begin
                last_wr_r <= wr_gnt;
            end
            // Availability travels with the read so an LCU switch
            // between grant and return does not alter its data
            if (rd_gnt) begin
                rd_avail_r <= avail_r;
            end
            rd_vld_r <= rd_gnt;
            ren_r    <= !ram_rd;
            done_r   <= wr_gnt && (wr_cnt == WR_LAST);
            hold_r   <= rd_data_o;
        end
    end

    assign rd_data_o  = rd_vld_r ? (rd_avail_r ? ram_data_i : '0)
                                 : hold_r;
    assign rd_vld_o   = rd_vld_r;
    assign rd_gnt_o   = rd_gnt;
    assign wr_gnt_o   = wr_gnt;
    assign lcu_done_o = done_r;
    assign ram_ren_o  = ren_r;

endmodule
